// File: rtl/day3_pkg.sv
// Shared constants and line-state encoding for the day-3 line scorer and its host-side model.
package day3_pkg;

  localparam int unsigned SCORE_W_DEF = 32;
  localparam int unsigned ScoreBits   = 7;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StMulti = 2'd2
  } line_st_e;

  // m*10 + d as two shifts and adds; 9*10+9 = 99 fits in 7 bits.
  function automatic logic [ScoreBits-1:0] times10_plus(input logic [3:0] m,
                                                         input logic [3:0] d);
    return {m, 3'b000} + {2'b00, m, 1'b0} + {3'b000, d};
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational byte classifier: decimal digit, end-of-line, or neither.
module ascii_digit_decode
  import day3_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_digit,
  output logic       is_eol,
  output logic [3:0] d
);

  assign is_digit = (in_char >= CH_0) && (in_char <= CH_9);
  assign is_eol   = (in_char == CH_LF);
  // Low nibble of '0'..'9' is the digit value; meaningless otherwise and ignored.
  assign d        = in_char[3:0];

endmodule

// File: rtl/line_scorer.sv
// Scores each text line as the largest two-digit number formed by an ordered digit pair.
module line_scorer
  import day3_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF,
  parameter int unsigned CNT_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_score,
  output logic [CNT_W-1:0]   line_count
);

  line_st_e             st_q         = StEmpty;
  logic [3:0]           max_d_q      = '0;
  logic [ScoreBits-1:0] best_q       = '0;
  logic [ScoreBits-1:0] score_q      = '0;
  logic                 out_valid_q  = 1'b0;
  logic [CNT_W-1:0]     line_count_q = '0;

  logic                 is_digit;
  logic                 is_eol;
  logic [3:0]           d;
  logic                 accept;
  logic [ScoreBits-1:0] cand;

  ascii_digit_decode u_decode (
    .in_char  (in_char),
    .is_digit (is_digit),
    .is_eol   (is_eol),
    .d        (d)
  );

  // A newline is only taken when the output register is free or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cand     = times10_plus(max_d_q, d);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= StEmpty;
      max_d_q      <= '0;
      best_q       <= '0;
      score_q      <= '0;
      out_valid_q  <= 1'b0;
      line_count_q <= '0;
    end else begin
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && is_digit) begin
        case (st_q)
          StEmpty: begin
            max_d_q <= d;
            best_q  <= '0;
            st_q    <= StOne;
          end
          default: begin
            best_q  <= (cand > best_q) ? cand : best_q;
            max_d_q <= (d > max_d_q) ? d : max_d_q;
            st_q    <= StMulti;
          end
        endcase
      end else if (accept && is_eol) begin
        // Blank lines produce no score; a lone digit scores zero.
        if (st_q != StEmpty) begin
          out_valid_q <= 1'b1;
          score_q     <= (st_q == StMulti) ? best_q : '0;
          if (line_count_q != '1) begin
            line_count_q <= line_count_q + CNT_W'(1);
          end
        end
        st_q    <= StEmpty;
        max_d_q <= '0;
        best_q  <= '0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_score  = {{(SCORE_W - ScoreBits){1'b0}}, score_q};
  assign line_count = line_count_q;

endmodule

// File: tb/tb_line_scorer.sv
// Self-checking bench for line_scorer: vector table, corner sequences and random streams.
module tb_line_scorer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_score;
  logic [8:0]  line_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] stim[$];
  int         got[$];
  int         exp_q[$];

  typedef struct {
    string stream;
    int    vpct;
    int    rpct;
    int    n;
    int    e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[6];

  line_scorer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_score  (out_score),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic step(input bit v, input logic [7:0] c, input bit r);
    @(negedge clk);
    in_valid = v; in_char = c; out_ready = r;
    #1;
  endtask

  task automatic load_str(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  // Feeds stim with random in_valid/out_ready gaps, collecting every taken score.
  task automatic run_stream(input int vpct, input int rpct);
    int idx = 0;
    int cyc = 0;
    int post = 0;
    bit done = 0;
    got.delete();
    while (!done) begin
      if (idx == stim.size()) post++;
      @(negedge clk);
      in_valid  = (idx < stim.size()) && (int'($urandom_range(99)) < vpct);
      in_char   = (idx < stim.size()) ? stim[idx] : 8'h00;
      out_ready = (int'($urandom_range(99)) < rpct);
      #1;
      if (out_valid && out_ready) got.push_back(int'(out_score));
      if (in_valid && in_ready) idx++;
      cyc++;
      if (post >= 2 && !out_valid) done = 1;
      if (cyc > 4000) begin
        n_chk++;
        $display("FAIL stream_timeout: consumed %0d of %0d bytes after %0d cycles",
                 idx, stim.size(), cyc);
        done = 1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Reference: per line, best 10*a[i]+a[j] over digit positions i<j.
  function automatic void ref_model();
    int digs[$];
    int best;
    exp_q.delete();
    foreach (stim[k]) begin
      if (stim[k] >= 8'h30 && stim[k] <= 8'h39) begin
        digs.push_back(int'(stim[k]) - 48);
      end else if (stim[k] == 8'h0A) begin
        if (digs.size() == 1) begin
          exp_q.push_back(0);
        end else if (digs.size() > 1) begin
          best = 0;
          for (int i = 0; i < digs.size(); i++)
            for (int j = i + 1; j < digs.size(); j++)
              if (10 * digs[i] + digs[j] > best) best = 10 * digs[i] + digs[j];
          exp_q.push_back(best);
        end
        digs.delete();
      end
    end
  endfunction

  initial begin
    int e[4];
    int sum;
    int n;
    int r;

    vecs[0] = '{"987654321111111\n811111111111119\n234234234234278\n818181911112111\n",
                100, 100, 4, 98, 89, 78, 92};
    vecs[1] = '{"5\n\n\n12\r\n", 100, 100, 2, 0, 12, 0, 0};
    vecs[2] = '{"19\n28\n", 60, 50, 2, 19, 28, 0, 0};
    vecs[3] = '{"0\n00\n10\n", 80, 80, 3, 0, 0, 10, 0};
    vecs[4] = '{"21\n1 2\r\n\r\n", 100, 70, 2, 21, 12, 0, 0};
    vecs[5] = '{"99\n3917\n", 70, 100, 2, 99, 97, 0, 0};

    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_score", int'(out_score), 0);
    check("rst_line_count", int'(line_count), 0);
    check("rst_in_ready", int'(in_ready), 1);

    foreach (vecs[v]) begin
      do_reset();
      load_str(vecs[v].stream);
      run_stream(vecs[v].vpct, vecs[v].rpct);
      e = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
      check($sformatf("vec%0d_count", v), got.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < got.size(); k++)
        check($sformatf("vec%0d_score%0d", v, k), got[k], e[k]);
      check($sformatf("vec%0d_line_count", v), int'(line_count), vecs[v].n);
      if (v == 0) begin
        sum = 0;
        foreach (got[k]) sum += got[k];
        check("sample_sum", sum, 357);
      end
    end

    // Back-pressure: first score held while the consumer stalls.
    do_reset();
    step(1, 8'h31, 0);
    step(1, 8'h39, 0);
    step(1, 8'h0A, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'h32, 0);
      check("bp_valid", int'(out_valid), 1);
      check("bp_score", int'(out_score), 19);
      check("bp_in_ready", int'(in_ready), 0);
    end
    step(1, 8'h32, 1);
    check("bp_release_ready", int'(in_ready), 1);
    step(1, 8'h38, 1);
    check("bp_drained", int'(out_valid), 0);
    step(1, 8'h0A, 1);
    step(0, 8'h00, 1);
    check("bp_second_valid", int'(out_valid), 1);
    check("bp_second_score", int'(out_score), 28);
    step(0, 8'h00, 1);
    check("bp_second_taken", int'(out_valid), 0);
    check("bp_line_count", int'(line_count), 2);

    // Newline every other cycle: each score exactly one cycle after its newline.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h30 + i), 1);
      if (i > 0) begin
        check("alt_valid", int'(out_valid), 1);
        check("alt_score", int'(out_score), 0);
      end
      step(1, 8'h0A, 1);
      check("alt_no_dup", int'(out_valid), 0);
    end
    step(0, 8'h00, 1);
    check("alt_last_valid", int'(out_valid), 1);
    step(0, 8'h00, 1);
    check("alt_last_taken", int'(out_valid), 0);
    check("alt_line_count", int'(line_count), 8);

    // Reset mid-line discards the partial line.
    do_reset();
    step(1, 8'h39, 1);
    step(1, 8'h39, 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    load_str("34\n");
    run_stream(100, 100);
    check("midrst_count", got.size(), 1);
    if (got.size() > 0) check("midrst_score", got[0], 34);
    check("midrst_line_count", int'(line_count), 1);

    // line_count saturates rather than wrapping.
    do_reset();
    stim.delete();
    for (int i = 0; i < 520; i++) begin
      stim.push_back(8'h31);
      stim.push_back(8'h0A);
    end
    run_stream(100, 100);
    check("sat_scores", got.size(), 520);
    check("sat_line_count", int'(line_count), 511);

    // Random streams against the reference model.
    for (int t = 0; t < 25; t++) begin
      stim.delete();
      n = $urandom_range(60, 20);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(99);
        if (r < 60)      stim.push_back(8'(8'h30 + $urandom_range(9)));
        else if (r < 75) stim.push_back(8'h0A);
        else if (r < 85) stim.push_back(8'h0D);
        else if (r < 90) stim.push_back(8'h20);
        else             stim.push_back(8'h61);
      end
      stim.push_back(8'h0A);
      ref_model();
      do_reset();
      run_stream(int'($urandom_range(100, 40)), int'($urandom_range(100, 30)));
      check($sformatf("rnd%0d_count", t), got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
        check($sformatf("rnd%0d_score%0d", t, k), got[k], exp_q[k]);
      check($sformatf("rnd%0d_line_count", t), int'(line_count), exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
